timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
- Programmable countdown timer on the processor device bus, mapped in the device window 0x00007F00-0x00007FFF.
- It is the responder to the controller's device store strobe (PrWe) and device reads.
- It drives the IntReq line that moves the multicycle controller into its interrupt state.
- It has three word registers: CTRL, PRESET and COUNT. It supports a one-shot mode and an auto-reload mode.

Parameters:
- CNT_W, 32, width of PRESET and COUNT
- RST_PRESET, 0, reset value of PRESET

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- Addr  input  2  word offset PrAddr[3:2]; 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- WE  input  1  write strobe; high for one cycle per device store
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr
- IRQ  output  1  interrupt request to the controller (IntReq)

Behaviour:
- Reset (rst=1 at an edge) values:
  - CTRL=0
  - PRESET=RST_PRESET
  - COUNT=0
  - irq_pend=0
  - state=IDLE
  - IRQ=0
  - Dout follows Addr (CTRL=0 after reset).
- CTRL bit fields:
  - bit0 EN
  - bits2:1 MODE (00 one-shot, 01 auto-reload; 10 and 11 behave as 00)
  - bit3 IM, the interrupt mask
  - bits31:4 read as 0; writes to them are ignored
- Writes, when WE=1:
  - Addr=0 updates CTRL[3:0].
  - Addr=1 updates PRESET. The new value is used at the next LOAD only; a count already in progress is not altered.
  - Addr=2 and Addr=3: the write is ignored. COUNT is read-only.
- Reads: Dout = CTRL (zero-extended), PRESET, COUNT, or 0 for Addr=3. No read side effects.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE; COUNT holds its value.
    - Else if COUNT==0, go to INT and set irq_pend=1.
    - Else COUNT <= COUNT-1.
  - INT:
    - MODE one-shot: EN <= 0, go to IDLE; irq_pend stays set.
    - MODE auto-reload: go to LOAD; irq_pend is cleared on leaving INT, giving a 1-cycle pulse.
- Latency:
  - From the edge that writes EN=1 with PRESET=N: LOAD at +1 edge, COUNT=N at +2, COUNT=0 at +2+N, INT (irq_pend=1) at +3+N.
  - PRESET=0 reaches INT 3 edges after enable.
- IRQ = irq_pend & IM, registered-state based, with no combinational path from Din/WE.
- irq_pend clear, one-shot mode: cleared by any write to CTRL or PRESET. The write takes effect at that edge.
- Simultaneous events:
  - A CTRL write in the same edge as INT's EN<=0 takes priority. The software value of EN is kept, irq_pend is cleared, and the FSM still goes to IDLE. If the written EN=1, IDLE then proceeds to LOAD.
  - A CTRL write with EN=0 during LOAD or CNT returns the FSM to IDLE at the following edge.
- No wrap-around: COUNT never decrements below 0.
- rst mid-count: rst restores all reset values at that edge regardless of state. IRQ is 0 in the next cycle.

Decomposition:
- Shared package timer_pkg holds:
  - register offsets ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2
  - CTRL bit positions EN/MODE/IM
  - mode codes MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01
  - FSM state encodings (2-bit)
  - the device base 24'h00007F, shared with the controller's hit decode
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset, then read Addr 0/1/2 -> Dout 0, RST_PRESET, 0; IRQ=0.
- Write PRESET=3, write CTRL=0x9 (EN, IM, one-shot) at edge E.
  - COUNT reads 3,2,1,0 at E+2..E+5.
  - IRQ=1 after E+6.
  - CTRL reads 0x8 after E+7; IRQ stays 1 until a CTRL write of 0x8 clears it next cycle.
- PRESET=2, CTRL=0xB (auto-reload, IM):
  - IRQ pulses exactly 1 cycle every 5 cycles.
  - A PRESET=4 write mid-count changes the period to 7 only after the next reload.
- CTRL=0x1 (IM=0), PRESET=1: state reaches INT and irq_pend sets, but IRQ stays 0. A later CTRL=0x8 write clears irq_pend, so IRQ stays 0.
- Write to Addr=2 value 0xFFFF during counting -> COUNT sequence unaffected; write to Addr=3 -> reads 0.
- Assert rst with COUNT=5 in CNT -> next cycle state IDLE, COUNT=0, CTRL=0, IRQ=0. With EN=0, PRESET=0 writes cause no IRQ.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer device: register map, CTRL fields, modes and
// FSM encodings. DEV_BASE is also used by the controller's device-window hit decode.
package timer_pkg;

   localparam logic [23:0] DEV_BASE = 24'h00007F;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StCnt  = 2'd2,
      StInt  = 2'd3
   } timer_state_e;

   function automatic logic dev_hit(input logic [31:0] addr);
      return addr[31:8] == DEV_BASE;
   endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer with one-shot and auto-reload modes, CTRL/PRESET/COUNT
// registers on the device bus, and a masked interrupt request to the controller.
module timer_dev
   import timer_pkg::*;
#(
   parameter int unsigned      CNT_W      = 32,
   parameter logic [CNT_W-1:0] RST_PRESET = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   logic [3:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             irq_pend_q, irq_pend_d;
   timer_state_e     state_q, state_d;

   logic en;
   logic reload;
   logic wr_ctrl;
   logic wr_preset;
   logic irq_set;

   assign en        = ctrl_q[CTRL_EN];
   assign reload    = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
   assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
   assign wr_preset = WE && (Addr == ADDR_PRESET);

   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_pend_d = irq_pend_q;
      state_d    = state_q;
      irq_set    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (en) state_d = StLoad;
         end
         StLoad: begin
            count_d = preset_q;
            state_d = en ? StCnt : StIdle;
         end
         StCnt: begin
            if (!en) begin
               state_d = StIdle;
            end else if (count_q == '0) begin
               state_d = StInt;
               irq_set = 1'b1;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         StInt: begin
            if (reload) begin
               state_d    = StLoad;
               irq_pend_d = 1'b0;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
               state_d         = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Software writes override the FSM's own EN clear on the same edge.
      if (wr_ctrl) ctrl_d = Din[3:0];
      if (wr_preset) preset_d = CNT_W'(Din);

      // In one-shot mode a CTRL/PRESET write acknowledges the interrupt; a new
      // expiry on the same edge still wins.
      if ((wr_ctrl || wr_preset) && !reload) irq_pend_d = 1'b0;
      if (irq_set) irq_pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q     <= '0;
         preset_q   <= RST_PRESET;
         count_q    <= '0;
         irq_pend_q <= 1'b0;
         state_q    <= StIdle;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_pend_q <= irq_pend_d;
         state_q    <= state_d;
      end
   end

   always_comb begin
      Dout = '0;
      case (Addr)
         ADDR_CTRL:   Dout = {28'b0, ctrl_q};
         ADDR_PRESET: Dout = 32'(preset_q);
         ADDR_COUNT:  Dout = 32'(count_q);
         default:     Dout = '0;
      endcase
   end

   assign IRQ = irq_pend_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev: one-shot, auto-reload, masking,
// read-only COUNT, simultaneous CTRL write at INT, and mid-count reset.
module tb_timer_dev;
   import timer_pkg::*;

   localparam logic [31:0] RST_P = 32'h0000_005A;

   logic        clk;
   logic        rst;
   logic [1:0]  Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int checks = 0;
   int errors = 0;

   timer_dev #(
      .CNT_W      (32),
      .RST_PRESET (RST_P)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .Addr (Addr),
      .WE   (WE),
      .Din  (Din),
      .Dout (Dout),
      .IRQ  (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just past the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write takes effect at the edge inside this task; returns just past that edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = a;
      Din  = d;
      WE   = 1'b1;
      step();
      WE   = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
      Addr = a;
      #1;
      check_eq(tag, Dout, exp);
   endtask

   initial begin
      rst  = 1'b1;
      WE   = 1'b0;
      Addr = ADDR_CTRL;
      Din  = '0;
      step();
      step();
      rst = 1'b0;

      // Reset values
      rd(ADDR_CTRL, "rst_ctrl", 32'h0);
      rd(ADDR_PRESET, "rst_preset", RST_P);
      rd(ADDR_COUNT, "rst_count", 32'h0);
      rd(2'd3, "rst_rsvd", 32'h0);
      check_eq("rst_irq", 32'(IRQ), 32'h0);

      // Upper CTRL bits are not writable
      wr(ADDR_CTRL, 32'hFFFF_FFF0);
      rd(ADDR_CTRL, "ctrl_upper", 32'h0);

      // One-shot, PRESET=3, enable at edge E
      wr(ADDR_PRESET, 32'd3);
      wr(ADDR_CTRL, 32'h9);                 // E
      Addr = ADDR_COUNT;
      step();                               // E+1 (LOAD)
      for (int c = 2; c <= 5; c++) begin
         step();
         rd(ADDR_COUNT, "os_count", 32'(5 - c));
         check_eq("os_irq_low", 32'(IRQ), 32'h0);
      end
      step();                               // E+6 INT
      check_eq("os_irq_set", 32'(IRQ), 32'h1);
      rd(ADDR_COUNT, "os_nowrap", 32'h0);
      step();                               // E+7 IDLE, EN cleared
      rd(ADDR_CTRL, "os_en_clr", 32'h8);
      check_eq("os_irq_hold", 32'(IRQ), 32'h1);
      step();
      check_eq("os_irq_hold2", 32'(IRQ), 32'h1);
      rd(ADDR_COUNT, "os_nowrap2", 32'h0);
      wr(ADDR_CTRL, 32'h8);
      check_eq("os_irq_ack", 32'(IRQ), 32'h0);

      // Auto-reload, PRESET=2 -> period 5
      wr(ADDR_PRESET, 32'd2);
      wr(ADDR_CTRL, 32'hB);                 // E
      Addr = ADDR_COUNT;
      for (int c = 1; c <= 15; c++) begin
         step();
         check_eq("ar_irq_p5", 32'(IRQ), 32'((c % 5) == 0));
      end
      step();
      step();                               // E+17
      rd(ADDR_COUNT, "ar_count_mid", 32'd2);
      wr(ADDR_PRESET, 32'd4);               // E+18, current count not altered
      check_eq("ar_irq_e18", 32'(IRQ), 32'h0);
      rd(ADDR_COUNT, "ar_count_keep", 32'd1);
      for (int c = 19; c <= 34; c++) begin
         step();
         check_eq("ar_irq_p7", 32'(IRQ), 32'((c == 20) || (c == 27) || (c == 34)));
         if (c == 22) rd(ADDR_COUNT, "ar_count_new", 32'd4);
      end
      wr(ADDR_CTRL, 32'h0);                 // leaves INT, stops
      check_eq("ar_stop_irq", 32'(IRQ), 32'h0);
      step();
      step();
      check_eq("ar_stopped", 32'(IRQ), 32'h0);

      // Masked: IM=0, PRESET=1
      wr(ADDR_PRESET, 32'd1);
      wr(ADDR_CTRL, 32'h1);                 // E, INT at E+4
      for (int c = 1; c <= 6; c++) begin
         step();
         check_eq("mask_irq", 32'(IRQ), 32'h0);
      end
      rd(ADDR_CTRL, "mask_en_clr", 32'h0);
      wr(ADDR_CTRL, 32'h8);                 // clears pending as IM is set
      check_eq("mask_ack_irq", 32'(IRQ), 32'h0);
      step();
      check_eq("mask_ack_irq2", 32'(IRQ), 32'h0);

      // COUNT read-only, reserved reads 0, then reset mid-count
      wr(ADDR_PRESET, 32'd7);
      wr(ADDR_CTRL, 32'h1);                 // E
      step();
      step();                               // E+2
      rd(ADDR_COUNT, "ro_count7", 32'd7);
      wr(ADDR_COUNT, 32'h0000_FFFF);        // E+3
      rd(ADDR_COUNT, "ro_count6", 32'd6);
      wr(2'd3, 32'h1234_5678);              // E+4
      rd(2'd3, "ro_rsvd", 32'h0);
      rd(ADDR_COUNT, "ro_count5", 32'd5);
      rd(ADDR_PRESET, "ro_preset", 32'd7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      rd(ADDR_COUNT, "mid_rst_count", 32'h0);
      rd(ADDR_CTRL, "mid_rst_ctrl", 32'h0);
      rd(ADDR_PRESET, "mid_rst_preset", RST_P);
      check_eq("mid_rst_irq", 32'(IRQ), 32'h0);
      step();
      rd(ADDR_COUNT, "mid_rst_idle", 32'h0);

      // EN=0: PRESET=0 writes do nothing
      wr(ADDR_CTRL, 32'h8);
      wr(ADDR_PRESET, 32'h0);
      for (int c = 0; c < 4; c++) begin
         step();
         check_eq("dis_irq", 32'(IRQ), 32'h0);
      end
      rd(ADDR_COUNT, "dis_count", 32'h0);

      // PRESET=0 reaches INT 3 edges after enable
      wr(ADDR_CTRL, 32'h9);                 // E
      step();
      check_eq("p0_irq_e1", 32'(IRQ), 32'h0);
      step();
      check_eq("p0_irq_e2", 32'(IRQ), 32'h0);
      step();
      check_eq("p0_irq_e3", 32'(IRQ), 32'h1);

      // CTRL write on the INT edge: software EN kept, pending cleared, restarts
      wr(ADDR_CTRL, 32'h9);                 // E+4
      rd(ADDR_CTRL, "sim_ctrl", 32'h9);
      check_eq("sim_irq_clr", 32'(IRQ), 32'h0);
      step();
      check_eq("sim_irq_e5", 32'(IRQ), 32'h0);
      step();
      check_eq("sim_irq_e6", 32'(IRQ), 32'h0);
      step();
      check_eq("sim_irq_e7", 32'(IRQ), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
